// File: rtl/wb_register_file.sv
// Write-back register file: 32 GPRs (GPR0 hard-wired to zero), 32 FPRs and
// the HI/LO pair. Writes commit on the rising clock edge; reads are
// combinational and can optionally see a same-cycle write-back.
module wb_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_reg_write,
    input  logic                  wb_write_floating,
    input  logic                  wb_hilo_write,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic [DATA_WIDTH-1:0] wb_write_data2,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic [ADDR_WIDTH-1:0] fs_addr,
    input  logic [ADDR_WIDTH-1:0] ft_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic [DATA_WIDTH-1:0] fs_data,
    output logic [DATA_WIDTH-1:0] ft_data,
    output logic [DATA_WIDTH-1:0] hi_data,
    output logic [DATA_WIDTH-1:0] lo_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] gpr [NUM_REGS];
    logic [DATA_WIDTH-1:0] fpr [NUM_REGS];
    logic [DATA_WIDTH-1:0] hi_reg;
    logic [DATA_WIDTH-1:0] lo_reg;

    logic gpr_wr_en;
    logic fpr_wr_en;

    assign gpr_wr_en = wb_reg_write && !wb_write_floating;
    assign fpr_wr_en = wb_reg_write &&  wb_write_floating;

    // GPR file: index 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_wr_en && (wb_write_addr != '0)) begin
            gpr[wb_write_addr] <= wb_write_data;
        end
    end

    // FPR file: every index, including 0, is an ordinary register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                fpr[i] <= '0;
            end
        end else if (fpr_wr_en) begin
            fpr[wb_write_addr] <= wb_write_data;
        end
    end

    // HI/LO pair, written independently of the GPR/FPR write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (wb_hilo_write) begin
            hi_reg <= wb_write_data2;
            lo_reg <= wb_write_data;
        end
    end

    // GPR read with zero register and optional write-through.
    function automatic logic [DATA_WIDTH-1:0] read_gpr(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = '0;
        if (addr != '0) begin
            value = gpr[addr];
            if (BYPASS && gpr_wr_en && (addr == wb_write_addr)) begin
                value = wb_write_data;
            end
        end
        return value;
    endfunction

    // FPR read with optional write-through.
    function automatic logic [DATA_WIDTH-1:0] read_fpr(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] value;
        value = fpr[addr];
        if (BYPASS && fpr_wr_en && (addr == wb_write_addr)) begin
            value = wb_write_data;
        end
        return value;
    endfunction

    // Combinational read ports; everything reads as zero while reset is held.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        fs_data = '0;
        ft_data = '0;
        hi_data = '0;
        lo_data = '0;
        if (rst_n) begin
            rs_data = read_gpr(rs_addr);
            rt_data = read_gpr(rt_addr);
            fs_data = read_fpr(fs_addr);
            ft_data = read_fpr(ft_addr);
            hi_data = hi_reg;
            lo_data = lo_reg;
            if (BYPASS && wb_hilo_write) begin
                hi_data = wb_write_data2;
                lo_data = wb_write_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_register_file.sv
// Scoreboard bench for wb_register_file: one instance with write-through
// bypass and one without, driven by the same directed write-back stream.
module tb_wb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic          wb_reg_write;
    logic          wb_write_floating;
    logic          wb_hilo_write;
    logic [AW-1:0] wb_write_addr;
    logic [DW-1:0] wb_write_data;
    logic [DW-1:0] wb_write_data2;
    logic [AW-1:0] rs_addr, rt_addr, fs_addr, ft_addr;

    logic [DW-1:0] rs_b, rt_b, fs_b, ft_b, hi_b, lo_b;
    logic [DW-1:0] rs_n, rt_n, fs_n, ft_n, hi_n, lo_n;

    wb_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_write_floating(wb_write_floating),
        .wb_hilo_write(wb_hilo_write), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data), .wb_write_data2(wb_write_data2),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .fs_addr(fs_addr), .ft_addr(ft_addr),
        .rs_data(rs_b), .rt_data(rt_b), .fs_data(fs_b), .ft_data(ft_b),
        .hi_data(hi_b), .lo_data(lo_b)
    );

    wb_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst_n(rst_n),
        .wb_reg_write(wb_reg_write), .wb_write_floating(wb_write_floating),
        .wb_hilo_write(wb_hilo_write), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data), .wb_write_data2(wb_write_data2),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .fs_addr(fs_addr), .ft_addr(ft_addr),
        .rs_data(rs_n), .rt_data(rt_n), .fs_data(fs_n), .ft_data(ft_n),
        .hi_data(hi_n), .lo_data(lo_n)
    );

    // Port selectors: 0..5 bypass instance, 6..11 no-bypass instance
    localparam int RS_B = 0, RT_B = 1, FS_B = 2, FT_B = 3, HI_B = 4, LO_B = 5;
    localparam int RS_N = 6, RT_N = 7, FS_N = 8, FT_N = 9, HI_N = 10, LO_N = 11;

    typedef struct {
        string         name;
        int            sel;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    event sample_evt;
    int   vectors_applied = 0;
    int   miscompares     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] get_port(input int sel);
        case (sel)
            RS_B:    return rs_b;
            RT_B:    return rt_b;
            FS_B:    return fs_b;
            FT_B:    return ft_b;
            HI_B:    return hi_b;
            LO_B:    return lo_b;
            RS_N:    return rs_n;
            RT_N:    return rt_n;
            FS_N:    return fs_n;
            FT_N:    return ft_n;
            HI_N:    return hi_n;
            default: return lo_n;
        endcase
    endfunction

    // Monitor: whenever a sample is presented, drain and compare the scoreboard
    initial begin
        exp_t          e;
        logic [DW-1:0] act;
        forever begin
            @(sample_evt);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = get_port(e.sel);
                vectors_applied++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    // Drive one write-back beat at the falling edge, as MEM/WB would
    task automatic applyStimulus(input logic we, input logic fl, input logic hw,
                                 input logic [AW-1:0] addr,
                                 input logic [DW-1:0] d, input logic [DW-1:0] d2);
        @(negedge clk);
        wb_reg_write      = we;
        wb_write_floating = fl;
        wb_hilo_write     = hw;
        wb_write_addr     = addr;
        wb_write_data     = d;
        wb_write_data2    = d2;
    endtask

    task automatic go_idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic set_read_addr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic [AW-1:0] fs, input logic [AW-1:0] ft);
        rs_addr = rs;
        rt_addr = rt;
        fs_addr = fs;
        ft_addr = ft;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [DW-1:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic strobe();
        -> sample_evt;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n             = 1'b0;
        wb_reg_write      = 1'b0;
        wb_write_floating = 1'b0;
        wb_hilo_write     = 1'b0;
        wb_write_addr     = '0;
        wb_write_data     = '0;
        wb_write_data2    = '0;
        set_read_addr(5'd1, 5'd2, 5'd1, 5'd0);

        // Reset state
        #3;
        checkOutput("reset_rs", RS_B, 32'h0);
        checkOutput("reset_fs", FS_B, 32'h0);
        checkOutput("reset_ft", FT_N, 32'h0);
        checkOutput("reset_hi", HI_B, 32'h0);
        checkOutput("reset_lo", LO_N, 32'h0);
        strobe();
        @(negedge clk);
        rst_n = 1'b1;

        // GPR0 protection
        set_read_addr(5'd0, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
        #2;
        checkOutput("gpr0_during_byp", RS_B, 32'h0);
        strobe();
        @(posedge clk); #1;
        checkOutput("gpr0_after_byp", RT_B, 32'h0);
        checkOutput("gpr0_after_nob", RS_N, 32'h0);
        strobe();
        go_idle(); #2;
        checkOutput("gpr0_idle_byp", RS_B, 32'h0);
        strobe();

        // Bypass: new value visible before the edge only with BYPASS=1
        set_read_addr(5'd0, 5'd9, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd9, 32'h55AA55AA, 32'h0);
        #2;
        checkOutput("bypass_rt_byp", RT_B, 32'h55AA55AA);
        checkOutput("bypass_rt_nob_old", RT_N, 32'h0);
        strobe();
        @(posedge clk); #1;
        checkOutput("bypass_rt_nob_after", RT_N, 32'h55AA55AA);
        strobe();

        // File separation
        set_read_addr(5'd7, 5'd0, 5'd7, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd7, 32'h11111111, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd7, 32'h22222222, 32'h0);
        #2;
        checkOutput("sep_fs_byp_during", FS_B, 32'h22222222);
        checkOutput("sep_rs_byp_during", RS_B, 32'h11111111);
        checkOutput("sep_fs_nob_during", FS_N, 32'h0);
        strobe();
        go_idle(); #2;
        checkOutput("sep_rs_byp", RS_B, 32'h11111111);
        checkOutput("sep_fs_byp", FS_B, 32'h22222222);
        checkOutput("sep_rs_nob", RS_N, 32'h11111111);
        checkOutput("sep_fs_nob", FS_N, 32'h22222222);
        strobe();

        // FPR0 is writable
        set_read_addr(5'd0, 5'd0, 5'd7, 5'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 32'hCAFEF00D, 32'h0);
        go_idle(); #2;
        checkOutput("fpr0_ft_nob", FT_N, 32'hCAFEF00D);
        checkOutput("fpr0_ft_byp", FT_B, 32'hCAFEF00D);
        checkOutput("fpr0_rs0_byp", RS_B, 32'h0);
        strobe();

        // HI/LO together with a GPR write
        set_read_addr(5'd3, 5'd3, 5'd3, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000ABCD, 32'h00001234);
        #2;
        checkOutput("hilo_hi_byp_during", HI_B, 32'h00001234);
        checkOutput("hilo_lo_byp_during", LO_B, 32'h0000ABCD);
        checkOutput("hilo_hi_nob_during", HI_N, 32'h0);
        strobe();
        go_idle(); #2;
        checkOutput("hilo_hi_nob", HI_N, 32'h00001234);
        checkOutput("hilo_lo_nob", LO_N, 32'h0000ABCD);
        checkOutput("hilo_gpr3_nob", RS_N, 32'h0000ABCD);
        checkOutput("hilo_fpr3_untouched", FS_N, 32'h0);
        strobe();

        // Disabled write leaves GPR4/FPR4 alone
        set_read_addr(5'd4, 5'd0, 5'd4, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd4, 32'hA0A0A0A0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd4, 32'h0B0B0B0B, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd4, 32'h12345678, 32'h0);
        #2;
        checkOutput("disabled_rs_byp_during", RS_B, 32'hA0A0A0A0);
        strobe();
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd4, 32'h12345678, 32'h0);
        #2;
        checkOutput("disabled_fs_byp_during", FS_B, 32'h0B0B0B0B);
        strobe();
        go_idle(); #2;
        checkOutput("disabled_rs_nob", RS_N, 32'hA0A0A0A0);
        checkOutput("disabled_fs_nob", FS_N, 32'h0B0B0B0B);
        checkOutput("disabled_hi_kept", HI_N, 32'h00001234);
        strobe();

        // Asynchronous reset mid-cycle
        set_read_addr(5'd5, 5'd3, 5'd7, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
        go_idle(); #2;
        checkOutput("pre_reset_rs5", RS_N, 32'hDEADBEEF);
        strobe();
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_rs5_byp", RS_B, 32'h0);
        checkOutput("async_reset_rs5_nob", RS_N, 32'h0);
        checkOutput("async_reset_hi", HI_B, 32'h0);
        checkOutput("async_reset_lo", LO_N, 32'h0);
        strobe();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("post_reset_rs5", RS_N, 32'h0);
        checkOutput("post_reset_rt3", RT_N, 32'h0);
        checkOutput("post_reset_fs7", FS_N, 32'h0);
        checkOutput("post_reset_ft0", FT_N, 32'h0);
        strobe();

        // Reset held across a rising edge blocks a pending write
        set_read_addr(5'd6, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd6, 32'h77777777, 32'h66666666);
        rst_n = 1'b0;
        @(posedge clk); #1;
        wb_reg_write  = 1'b0;
        wb_hilo_write = 1'b0;
        rst_n         = 1'b1;
        #1;
        checkOutput("reset_blocks_write_rs6", RS_N, 32'h0);
        checkOutput("reset_blocks_write_hi", HI_N, 32'h0);
        strobe();

        // First write after reset behaves normally
        set_read_addr(5'd5, 5'd5, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd5, 32'h01020304, 32'h0);
        go_idle(); #2;
        checkOutput("first_write_rs_nob", RS_N, 32'h01020304);
        checkOutput("first_write_rt_byp", RT_B, 32'h01020304);
        strobe();

        strobe();
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
